// File: rtl/fetch_priv_ctrl.sv
// fetch_priv_ctrl: serialises fetch around IBAR / CSR / TLB instructions.
// In: flags from pre-decode, EX commits, completions. Out: stall, flush, redirect.
module fetch_priv_ctrl #(
  parameter int IDLE_HOLD = 2,
  parameter int HOLD_W    = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        flag_valid,
  input  logic [31:0] flag_pc,
  input  logic [1:0]  ibar_flag,
  input  logic [1:0]  csr_flag,
  input  logic [1:0]  tlb_flag,
  input  logic        ibar_from_ex,
  input  logic        csr_from_ex,
  input  logic        tlb_from_ex,
  input  logic        icache_idle,
  input  logic        dcache_idle,
  input  logic        csr_done,
  input  logic        tlb_done,
  output logic        fetch_stall,
  output logic        flush_younger,
  output logic        set_pc,
  output logic [31:0] set_pc_target,
  output logic [2:0]  ctrl_state
);

  typedef enum logic [2:0] {
    IDLE            = 3'b000,
    WAIT_EX_IBAR    = 3'b001,
    WAIT_EX_CSR     = 3'b010,
    WAIT_CACHE_IDLE = 3'b011,
    WAIT_CSR_OK     = 3'b100,
    WAIT_TLB_OK     = 3'b101,
    REDIRECT        = 3'b110,
    WAIT_EX_TLB     = 3'b111
  } state_e;

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(IDLE_HOLD - 1);

  state_e            state_q, state_d;
  logic [31:0]       target_q, target_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;

  logic [1:0] mask;
  logic [1:0] ib, cs, tl;
  logic       any0, any1, detect;
  logic       sel_ib, sel_cs;
  logic       both_idle;

  // A packet starting at pc[2]=1 only carries slot0.
  assign mask      = flag_pc[2] ? 2'b01 : 2'b11;
  assign ib        = ibar_flag & mask;
  assign cs        = csr_flag & mask;
  assign tl        = tlb_flag & mask;
  assign any0      = ib[0] | cs[0] | tl[0];
  assign any1      = ib[1] | cs[1] | tl[1];
  assign detect    = (state_q == IDLE) && flag_valid && (any0 || any1);
  assign sel_ib    = any0 ? ib[0] : ib[1];
  assign sel_cs    = any0 ? cs[0] : cs[1];
  assign both_idle = icache_idle && dcache_idle;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (detect && !flush) begin
          target_d = flag_pc + (any0 ? 32'd4 : 32'd8);
          if (sel_ib)      state_d = WAIT_EX_IBAR;
          else if (sel_cs) state_d = WAIT_EX_CSR;
          else             state_d = WAIT_EX_TLB;
        end
      end
      WAIT_EX_IBAR: begin
        cnt_d = '0;
        if (ibar_from_ex) state_d = WAIT_CACHE_IDLE;
        else if (flush)   state_d = IDLE;
      end
      WAIT_EX_CSR: begin
        cnt_d = '0;
        if (csr_from_ex) state_d = WAIT_CSR_OK;
        else if (flush)  state_d = IDLE;
      end
      WAIT_EX_TLB: begin
        cnt_d = '0;
        if (tlb_from_ex) state_d = WAIT_TLB_OK;
        else if (flush)  state_d = IDLE;
      end
      WAIT_CACHE_IDLE: begin
        if (!both_idle) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_MAX) begin
          cnt_d   = '0;
          state_d = REDIRECT;
        end else begin
          cnt_d = cnt_q + HOLD_W'(1);
        end
      end
      WAIT_CSR_OK: if (csr_done) state_d = REDIRECT;
      WAIT_TLB_OK: if (tlb_done) state_d = REDIRECT;
      REDIRECT:    state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  assign fetch_stall   = detect || (state_q != IDLE);
  assign flush_younger = (state_q == WAIT_EX_IBAR) ||
                         (state_q == WAIT_EX_CSR)  ||
                         (state_q == WAIT_EX_TLB);
  assign set_pc        = (state_q == REDIRECT);
  assign set_pc_target = target_q;
  assign ctrl_state    = state_q;

endmodule

// File: tb/tb_fetch_priv_ctrl.sv
// tb_fetch_priv_ctrl: directed scenario tasks for fetch_priv_ctrl.
// Inputs change 1ns after posedge; outputs are sampled before the next edge.
module tb_fetch_priv_ctrl;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        flag_valid = 1'b0;
  logic [31:0] flag_pc = '0;
  logic [1:0]  ibar_flag = '0, csr_flag = '0, tlb_flag = '0;
  logic        ibar_from_ex = 1'b0, csr_from_ex = 1'b0, tlb_from_ex = 1'b0;
  logic        icache_idle = 1'b0, dcache_idle = 1'b0;
  logic        csr_done = 1'b0, tlb_done = 1'b0;
  logic        fetch_stall, flush_younger, set_pc;
  logic [31:0] set_pc_target;
  logic [2:0]  ctrl_state;

  int n_chk = 0;
  int n_fail = 0;

  fetch_priv_ctrl dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .flag_valid(flag_valid), .flag_pc(flag_pc),
    .ibar_flag(ibar_flag), .csr_flag(csr_flag), .tlb_flag(tlb_flag),
    .ibar_from_ex(ibar_from_ex), .csr_from_ex(csr_from_ex),
    .tlb_from_ex(tlb_from_ex),
    .icache_idle(icache_idle), .dcache_idle(dcache_idle),
    .csr_done(csr_done), .tlb_done(tlb_done),
    .fetch_stall(fetch_stall), .flush_younger(flush_younger),
    .set_pc(set_pc), .set_pc_target(set_pc_target),
    .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    flush = 0; flag_valid = 0; flag_pc = '0;
    ibar_flag = 0; csr_flag = 0; tlb_flag = 0;
    ibar_from_ex = 0; csr_from_ex = 0; tlb_from_ex = 0;
    icache_idle = 0; dcache_idle = 0; csr_done = 0; tlb_done = 0;
  endtask

  task automatic test_reset();
    #2;
    n_chk++;
    if (ctrl_state !== 3'd0 || set_pc !== 1'b0 || fetch_stall !== 1'b0 ||
        flush_younger !== 1'b0 || set_pc_target !== 32'd0) begin
      n_fail++;
      $display("FAIL reset st=%0d pc=%b stall=%b fy=%b tgt=%h exp 0",
               ctrl_state, set_pc, fetch_stall, flush_younger, set_pc_target);
    end
    tick(); rstn = 1; tick();
  endtask

  task automatic test_ibar();
    flag_valid = 1; flag_pc = 32'h1C00_0000; ibar_flag = 2'b01;
    #1;
    n_chk++;
    if (fetch_stall !== 1'b1) begin
      n_fail++; $display("FAIL ibar_det_stall got %b exp 1", fetch_stall);
    end
    tick(); clr();
    n_chk++;
    if (ctrl_state !== 3'd1 || flush_younger !== 1'b1) begin
      n_fail++; $display("FAIL ibar_wait_ex st=%0d fy=%b exp 1/1", ctrl_state, flush_younger);
    end
    ibar_from_ex = 1; tick(); clr();
    n_chk++;
    if (ctrl_state !== 3'd3 || flush_younger !== 1'b0) begin
      n_fail++; $display("FAIL ibar_wait_cache st=%0d fy=%b exp 3/0", ctrl_state, flush_younger);
    end
    icache_idle = 1; dcache_idle = 1; tick();
    n_chk++;
    if (ctrl_state !== 3'd3 || set_pc !== 1'b0) begin
      n_fail++; $display("FAIL ibar_hold1 st=%0d set_pc=%b exp 3/0", ctrl_state, set_pc);
    end
    tick(); clr();
    n_chk++;
    if (ctrl_state !== 3'd6 || set_pc !== 1'b1 || set_pc_target !== 32'h1C00_0004) begin
      n_fail++;
      $display("FAIL ibar_redirect st=%0d set_pc=%b tgt=%h exp 6/1/1c000004",
               ctrl_state, set_pc, set_pc_target);
    end
    tick();
    n_chk++;
    if (ctrl_state !== 3'd0 || set_pc !== 1'b0 || fetch_stall !== 1'b0) begin
      n_fail++; $display("FAIL ibar_back_idle st=%0d set_pc=%b stall=%b exp 0/0/0",
                         ctrl_state, set_pc, fetch_stall);
    end
  endtask

  task automatic test_csr_slot1();
    flag_valid = 1; flag_pc = 32'h1C00_0010; csr_flag = 2'b10;
    tick(); clr();
    n_chk++;
    if (ctrl_state !== 3'd2) begin
      n_fail++; $display("FAIL csr_wait_ex got %0d exp 2", ctrl_state);
    end
    csr_from_ex = 1; csr_done = 1; tick(); clr();
    n_chk++;
    if (ctrl_state !== 3'd4) begin
      n_fail++; $display("FAIL csr_wait_ok got %0d exp 4", ctrl_state);
    end
    tick(); tick();
    n_chk++;
    if (ctrl_state !== 3'd4 || set_pc !== 1'b0) begin
      n_fail++; $display("FAIL csr_still_wait st=%0d set_pc=%b exp 4/0", ctrl_state, set_pc);
    end
    csr_done = 1; tick(); clr();
    n_chk++;
    if (set_pc !== 1'b1 || set_pc_target !== 32'h1C00_0018) begin
      n_fail++; $display("FAIL csr_redirect set_pc=%b tgt=%h exp 1/1c000018", set_pc, set_pc_target);
    end
    tick();
  endtask

  task automatic test_odd_packet();
    flag_valid = 1; flag_pc = 32'h1C00_0024; tlb_flag = 2'b10;
    #1;
    n_chk++;
    if (fetch_stall !== 1'b0) begin
      n_fail++; $display("FAIL odd_no_detect stall=%b exp 0", fetch_stall);
    end
    tick();
    n_chk++;
    if (ctrl_state !== 3'd0) begin
      n_fail++; $display("FAIL odd_stay_idle got %0d exp 0", ctrl_state);
    end
    tlb_flag = 2'b01; tick(); clr();
    n_chk++;
    if (ctrl_state !== 3'd7 || set_pc_target !== 32'h1C00_0028) begin
      n_fail++; $display("FAIL odd_tlb st=%0d tgt=%h exp 7/1c000028", ctrl_state, set_pc_target);
    end
    csr_from_ex = 1; ibar_from_ex = 1; tick(); clr();
    n_chk++;
    if (ctrl_state !== 3'd7) begin
      n_fail++; $display("FAIL odd_wrong_commit got %0d exp 7", ctrl_state);
    end
    tlb_from_ex = 1; tick(); clr();
    tlb_done = 1; tick(); clr();
    n_chk++;
    if (set_pc !== 1'b1 || set_pc_target !== 32'h1C00_0028) begin
      n_fail++; $display("FAIL odd_redirect set_pc=%b tgt=%h exp 1/1c000028", set_pc, set_pc_target);
    end
    flag_valid = 1; flag_pc = 32'h1C00_0080; ibar_flag = 2'b01;
    #1;
    n_chk++;
    if (set_pc !== 1'b1) begin
      n_fail++; $display("FAIL redirect_hold set_pc=%b exp 1", set_pc);
    end
    tick(); clr();
    n_chk++;
    if (ctrl_state !== 3'd0) begin
      n_fail++; $display("FAIL no_detect_in_redirect got %0d exp 0", ctrl_state);
    end
  endtask

  task automatic test_priority();
    flag_valid = 1; flag_pc = 32'h1C00_0040; ibar_flag = 2'b10; csr_flag = 2'b01;
    tick(); clr();
    n_chk++;
    if (ctrl_state !== 3'd2 || set_pc_target !== 32'h1C00_0044) begin
      n_fail++; $display("FAIL prio_slot st=%0d tgt=%h exp 2/1c000044", ctrl_state, set_pc_target);
    end
    flush = 1; tick(); clr();
    flag_valid = 1; flag_pc = 32'h1C00_0050; ibar_flag = 2'b01; tlb_flag = 2'b01;
    tick(); clr();
    n_chk++;
    if (ctrl_state !== 3'd1 || set_pc_target !== 32'h1C00_0054) begin
      n_fail++; $display("FAIL prio_same st=%0d tgt=%h exp 1/1c000054", ctrl_state, set_pc_target);
    end
    flush = 1; tick(); clr();
  endtask

  task automatic test_idle_glitch();
    flag_valid = 1; flag_pc = 32'h1C00_0100; ibar_flag = 2'b01;
    tick(); clr();
    ibar_from_ex = 1; tick(); clr();
    icache_idle = 1; dcache_idle = 1; tick();
    icache_idle = 1; dcache_idle = 0; tick();
    n_chk++;
    if (ctrl_state !== 3'd3 || set_pc !== 1'b0) begin
      n_fail++; $display("FAIL glitch_reset st=%0d set_pc=%b exp 3/0", ctrl_state, set_pc);
    end
    dcache_idle = 1; tick();
    n_chk++;
    if (ctrl_state !== 3'd3 || set_pc !== 1'b0) begin
      n_fail++; $display("FAIL glitch_one st=%0d set_pc=%b exp 3/0", ctrl_state, set_pc);
    end
    tick(); clr();
    n_chk++;
    if (set_pc !== 1'b1 || set_pc_target !== 32'h1C00_0104) begin
      n_fail++; $display("FAIL glitch_redirect set_pc=%b tgt=%h exp 1/1c000104", set_pc, set_pc_target);
    end
    tick();
  endtask

  task automatic test_flush();
    flag_valid = 1; flag_pc = 32'h1C00_0200; tlb_flag = 2'b01;
    tick(); clr();
    flush = 1; tick(); clr();
    n_chk++;
    if (ctrl_state !== 3'd0 || set_pc !== 1'b0) begin
      n_fail++; $display("FAIL flush_wait_ex st=%0d set_pc=%b exp 0/0", ctrl_state, set_pc);
    end
    tick();
    n_chk++;
    if (set_pc !== 1'b0 || fetch_stall !== 1'b0) begin
      n_fail++; $display("FAIL flush_no_pc set_pc=%b stall=%b exp 0/0", set_pc, fetch_stall);
    end
    flag_valid = 1; flag_pc = 32'h1C00_0300; tlb_flag = 2'b01;
    tick(); clr();
    tlb_from_ex = 1; tick(); clr();
    flush = 1; tick(); clr();
    n_chk++;
    if (ctrl_state !== 3'd5) begin
      n_fail++; $display("FAIL flush_post_ignored got %0d exp 5", ctrl_state);
    end
    tlb_done = 1; tick(); clr();
    n_chk++;
    if (set_pc !== 1'b1 || set_pc_target !== 32'h1C00_0304) begin
      n_fail++; $display("FAIL flush_post_redirect set_pc=%b tgt=%h exp 1/1c000304", set_pc, set_pc_target);
    end
    tick();
    flag_valid = 1; flag_pc = 32'h1C00_0400; csr_flag = 2'b01;
    tick(); clr();
    flush = 1; csr_from_ex = 1; tick(); clr();
    n_chk++;
    if (ctrl_state !== 3'd4) begin
      n_fail++; $display("FAIL flush_with_commit got %0d exp 4", ctrl_state);
    end
    csr_done = 1; tick(); clr(); tick();
    flush = 1; flag_valid = 1; flag_pc = 32'h1C00_0500; ibar_flag = 2'b01;
    tick(); clr();
    n_chk++;
    if (ctrl_state !== 3'd0) begin
      n_fail++; $display("FAIL flush_with_detect got %0d exp 0", ctrl_state);
    end
  endtask

  task automatic test_wrap_and_async_reset();
    flag_valid = 1; flag_pc = 32'hFFFF_FFF8; csr_flag = 2'b10;
    tick(); clr();
    n_chk++;
    if (ctrl_state !== 3'd2 || set_pc_target !== 32'h0000_0000) begin
      n_fail++; $display("FAIL wrap_target st=%0d tgt=%h exp 2/00000000", ctrl_state, set_pc_target);
    end
    #2 rstn = 0;
    #1;
    n_chk++;
    if (ctrl_state !== 3'd0 || set_pc_target !== 32'd0 || flush_younger !== 1'b0) begin
      n_fail++; $display("FAIL async_reset st=%0d tgt=%h fy=%b exp 0/0/0",
                         ctrl_state, set_pc_target, flush_younger);
    end
    tick(); rstn = 1; tick();
  endtask

  initial begin
    clr();
    test_reset();
    test_ibar();
    test_csr_slot1();
    test_odd_packet();
    test_priority();
    test_idle_glitch();
    test_flush();
    test_wrap_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_priv_ctrl.md
Name: fetch_priv_ctrl

Overview:
- Sequences fetch around privileged/serialising instructions (IBAR, CSR writes, TLB ops) found by the pre-decoder as a packet enters the IF1 FIFO.
- On detection it stalls fetch and drops younger packets, then waits for EX to commit the instruction.
- It then waits for the matching completion (both caches idle, CSR done, or TLB done) and redirects fetch to the instruction after the privileged one.

Parameters:
- IDLE_HOLD, 2: consecutive cycles icache_idle&&dcache_idle must both hold before an IBAR completes (1..15).
- HOLD_W, 4: width of the idle-hold counter.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- flush  in  1  pipeline flush from backend
- flag_valid  in  1  packet accepted into IF1 FIFO this cycle
- flag_pc  in  32  PC of that packet
- ibar_flag  in  2  bit0/bit1: slot0/slot1 is IBAR
- csr_flag  in  2  slot is CSR-modifying instruction
- tlb_flag  in  2  slot is TLB instruction
- ibar_from_ex  in  1  EX commits the IBAR
- csr_from_ex  in  1  EX commits the CSR instruction
- tlb_from_ex  in  1  EX commits the TLB instruction
- icache_idle  in  1  icache has no outstanding op
- dcache_idle  in  1  dcache has no outstanding op
- csr_done  in  1  CSR write visible
- tlb_done  in  1  TLB op finished
- fetch_stall  out  1  block new fetch/FIFO push
- flush_younger  out  1  discard younger fetched packets
- set_pc  out  1  one-cycle redirect pulse
- set_pc_target  out  32  redirect PC
- ctrl_state  out  3  current state, for debug/perf

Behaviour:
- Reset (async): state IDLE, set_pc_target=0, hold counter=0; set_pc=0, flush_younger=0, fetch_stall=0.
- States/encodings: IDLE 000, WAIT_EX_IBAR 001, WAIT_EX_CSR 010, WAIT_CACHE_IDLE 011, WAIT_CSR_OK 100, WAIT_TLB_OK 101, REDIRECT 110, WAIT_EX_TLB 111.
- Detect = IDLE && flag_valid && any flag bit set. If flag_pc[2]=1, bit1 of every flag is ignored (single-slot packet).
- Slot select: the lowest flagged slot wins. Within that slot, priority is ibar > csr > tlb.
- Target, registered on detect: slot0 gives flag_pc+4, slot1 gives flag_pc+8. Arithmetic is 32-bit, wrapping modulo 2^32.
- IDLE -> WAIT_EX_IBAR / WAIT_EX_CSR / WAIT_EX_TLB on detect.
- WAIT_EX_x -> post state when the matching *_from_ex is high: IBAR -> WAIT_CACHE_IDLE, CSR -> WAIT_CSR_OK, TLB -> WAIT_TLB_OK. Non-matching *_from_ex inputs are ignored.
- WAIT_CACHE_IDLE: counter increments while icache_idle&&dcache_idle, and clears to 0 otherwise. Go to REDIRECT when counter reaches IDLE_HOLD-1 with idle still high, i.e. after IDLE_HOLD consecutive idle cycles.
- WAIT_CSR_OK -> REDIRECT on csr_done. WAIT_TLB_OK -> REDIRECT on tlb_done. A done asserted in the same cycle as from_ex is not sampled; it must be present in the post state.
- REDIRECT: set_pc=1 for exactly one cycle with set_pc_target stable, then IDLE. A new detect is not accepted in the REDIRECT cycle.
- fetch_stall = detect || state!=IDLE (combinational, so the detection cycle already stalls).
- flush_younger = 1 in all WAIT_EX_x states.
- Flush in IDLE or WAIT_EX_x: next state IDLE, counter cleared, no set_pc.
- Flush together with the matching *_from_ex: commit wins, the post state is entered.
- Flush together with detect in IDLE: detect discarded.
- Flush in WAIT_CACHE_IDLE, WAIT_CSR_OK, WAIT_TLB_OK or REDIRECT is ignored: the instruction has already committed, so the redirect still happens.
- Reset mid-operation returns to IDLE immediately, asynchronously.
- No internal timeout: completion signals are guaranteed by the backend.

Test Plan:
- IBAR: flag_valid, flag_pc=0x1C000000, ibar_flag=01 -> WAIT_EX_IBAR; fetch_stall=1 in the detect cycle. ibar_from_ex -> WAIT_CACHE_IDLE. Caches idle 2 cycles (IDLE_HOLD=2) -> set_pc pulse, target 0x1C000004.
- CSR slot1: flag_pc=0x1C000010, csr_flag=10 -> WAIT_EX_CSR. csr_from_ex, then csr_done 3 cycles later -> set_pc with target 0x1C000018.
- Odd packet: flag_pc=0x1C000024, tlb_flag=10 -> no detect, fetch_stall=0. Then tlb_flag=01 -> target 0x1C000028.
- Priority: ibar_flag=10, csr_flag=01 -> WAIT_EX_CSR, target pc+4. Same-slot ibar=01 and tlb=01 -> WAIT_EX_IBAR.
- Idle glitch: in WAIT_CACHE_IDLE the idle pattern 1,0,1,1 -> set_pc only after the last two cycles.
- Flush: flush in WAIT_EX_TLB -> IDLE, no set_pc. Flush in WAIT_TLB_OK -> ignored, set_pc follows tlb_done. Flush with csr_from_ex -> WAIT_CSR_OK.
